// File: rtl/sq_commit_arb.sv
`default_nettype none
// ============================================================================
// Module   : sq_commit_arb
// Purpose  : Store-queue commit arbiter. Counts stores retired by the ROB that
//            still have to be written to memory, and arbitrates one shared
//            memory command port between those committed stores and the load
//            unit. Stores and loads alternate round-robin unless the pending
//            counter is full, in which case stores win. Every command is held
//            until mem_ack and is followed by at least one IDLE cycle, so the
//            SQ head has advanced before the next store is latched.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            rob_st_retire       - ROB retired one store this cycle
//            sq_head_addr/data   - address/data of the store at the SQ head
//            ld_req, ld_addr     - load request (held until ld_grant), address
//            mem_ack             - memory accepted the command this cycle
//            mem_cmd             - 0=NONE, 1=LOAD, 2=STORE (registered)
//            mem_addr, mem_data  - command address / store data (registered)
//            sq_rt_en            - pop the SQ head (store acknowledged)
//            ld_grant            - load acknowledged
//            pend_full           - pending counter saturated; stop retiring
//            ovf_err             - sticky: retire seen while pend_full
// Revision : 1.0 - initial release
// ============================================================================
module sq_commit_arb #(
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rob_st_retire,
  input  logic [63:0] sq_head_addr,
  input  logic [63:0] sq_head_data,
  input  logic        ld_req,
  input  logic [63:0] ld_addr,
  input  logic        mem_ack,
  output logic [1:0]  mem_cmd,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        sq_rt_en,
  output logic        ld_grant,
  output logic        pend_full,
  output logic        ovf_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       CMD_NONE  = 2'd0;
  localparam logic [1:0]       CMD_LOAD  = 2'd1;
  localparam logic [1:0]       CMD_STORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_REQ = 2'd1,
    LD_REQ = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             last_st_q,  last_st_d;
  logic             ovf_err_q,  ovf_err_d;
  logic [1:0]       mem_cmd_q,  mem_cmd_d;
  logic [63:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_data_q, mem_data_d;

  logic             st_pend;
  logic             pick_st;
  logic             pick_ld;

  assign pend_full = (pend_cnt_q == CNT_MAX);
  assign ovf_err   = ovf_err_q;
  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

  // --------------------------------------------------------------------------
  // Arbitration FSM: next state, command registers and acknowledge pulses.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_st_d  = last_st_q;
    mem_cmd_d  = mem_cmd_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    sq_rt_en   = 1'b0;
    ld_grant   = 1'b0;
    st_pend    = (pend_cnt_q != '0);
    pick_st    = 1'b0;
    pick_ld    = 1'b0;

    case (state_q)
      IDLE: begin
        // A full counter forces the store; otherwise alternate with the
        // type that was granted last (last_st_q=0 after reset -> store first).
        pick_st = st_pend && (!ld_req || pend_full || !last_st_q);
        pick_ld = ld_req && !pick_st;
        if (pick_st) begin
          state_d    = ST_REQ;
          mem_cmd_d  = CMD_STORE;
          mem_addr_d = sq_head_addr;
          mem_data_d = sq_head_data;
        end else if (pick_ld) begin
          state_d    = LD_REQ;
          mem_cmd_d  = CMD_LOAD;
          mem_addr_d = ld_addr;
          mem_data_d = 64'd0;
        end
      end

      ST_REQ: begin
        if (mem_ack) begin
          sq_rt_en   = 1'b1;
          last_st_d  = 1'b1;
          state_d    = IDLE;
          mem_cmd_d  = CMD_NONE;
          mem_addr_d = 64'd0;
          mem_data_d = 64'd0;
        end
      end

      LD_REQ: begin
        // Held to mem_ack even if ld_req drops; there is no abort path.
        if (mem_ack) begin
          ld_grant   = 1'b1;
          last_st_d  = 1'b0;
          state_d    = IDLE;
          mem_cmd_d  = CMD_NONE;
          mem_addr_d = 64'd0;
          mem_data_d = 64'd0;
        end
      end

      default: begin
        state_d    = IDLE;
        mem_cmd_d  = CMD_NONE;
        mem_addr_d = 64'd0;
        mem_data_d = 64'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending-commit counter. A retire and a pop in the same cycle cancel,
  // which also holds the counter at max when the ROB retires while full.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    ovf_err_d  = ovf_err_q | (rob_st_retire & pend_full);
    if (rob_st_retire && !sq_rt_en && !pend_full) begin
      pend_cnt_d = pend_cnt_q + CNT_ONE;
    end else if (sq_rt_en && !rob_st_retire) begin
      pend_cnt_d = pend_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_cnt_q <= '0;
      last_st_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
      mem_cmd_q  <= CMD_NONE;
      mem_addr_q <= 64'd0;
      mem_data_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      pend_cnt_q <= pend_cnt_d;
      last_st_q  <= last_st_d;
      ovf_err_q  <= ovf_err_d;
      mem_cmd_q  <= mem_cmd_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sq_commit_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sq_commit_arb
// Purpose  : Self-checking bench for sq_commit_arb. A behavioural model of the
//            arbiter (integer pending count, current command, round-robin
//            flag) is stepped once per cycle and compared with every DUT
//            output; directed sequences pin known values, then randomized
//            traffic with occasional asynchronous resets follows.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sq_commit_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rob_st_retire;
  logic [63:0] sq_head_addr;
  logic [63:0] sq_head_data;
  logic        ld_req;
  logic [63:0] ld_addr;
  logic        mem_ack;
  logic [1:0]  mem_cmd;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic        sq_rt_en;
  logic        ld_grant;
  logic        pend_full;
  logic        ovf_err;

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_cnt;
  bit          m_ovf;
  bit          m_last_st;
  int          m_cmd;
  logic [63:0] m_addr;
  logic [63:0] m_data;
  bit          exp_ld_grant;

  always #5 clk = ~clk;

  sq_commit_arb #(.CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rob_st_retire(rob_st_retire),
    .sq_head_addr (sq_head_addr),
    .sq_head_data (sq_head_data),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .mem_ack      (mem_ack),
    .mem_cmd      (mem_cmd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .sq_rt_en     (sq_rt_en),
    .ld_grant     (ld_grant),
    .pend_full    (pend_full),
    .ovf_err      (ovf_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: compare this cycle's outputs, then apply the cycle's
  // inputs to obtain the state after the next rising edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : model
    bit e_pop;
    bit e_grant;
    bit full;
    int old_cnt;
    if (!rst_n) begin
      m_cnt = 0; m_ovf = 0; m_last_st = 0; m_cmd = 0;
      m_addr = 64'd0; m_data = 64'd0; exp_ld_grant = 0;
      check("rst_mem_cmd",   {62'd0, mem_cmd}, 64'd0);
      check("rst_mem_addr",  mem_addr, 64'd0);
      check("rst_mem_data",  mem_data, 64'd0);
      check("rst_sq_rt_en",  {63'd0, sq_rt_en}, 64'd0);
      check("rst_ld_grant",  {63'd0, ld_grant}, 64'd0);
      check("rst_pend_full", {63'd0, pend_full}, 64'd0);
      check("rst_ovf_err",   {63'd0, ovf_err}, 64'd0);
    end else begin
      full    = (m_cnt == 7);
      e_pop   = (m_cmd == 2) && mem_ack;
      e_grant = (m_cmd == 1) && mem_ack;
      check("mem_cmd", {62'd0, mem_cmd}, 64'(m_cmd));
      if (m_cmd != 0) check("mem_addr", mem_addr, m_addr);
      check("mem_data", mem_data, (m_cmd == 2) ? m_data : 64'd0);
      check("sq_rt_en", {63'd0, sq_rt_en}, {63'd0, e_pop});
      check("ld_grant", {63'd0, ld_grant}, {63'd0, e_grant});
      check("pend_full", {63'd0, pend_full}, {63'd0, full});
      check("ovf_err", {63'd0, ovf_err}, {63'd0, m_ovf});
      exp_ld_grant = e_grant;

      old_cnt = m_cnt;
      if (rob_st_retire && full) m_ovf = 1;
      if (rob_st_retire && !e_pop && !full) m_cnt = m_cnt + 1;
      else if (e_pop && !rob_st_retire) m_cnt = m_cnt - 1;

      if (m_cmd != 0) begin
        if (mem_ack) begin
          m_last_st = (m_cmd == 2);
          m_cmd = 0; m_addr = 64'd0; m_data = 64'd0;
        end
      end else if (old_cnt > 0 && (!ld_req || full || !m_last_st)) begin
        m_cmd = 2; m_addr = sq_head_addr; m_data = sq_head_data;
      end else if (ld_req) begin
        m_cmd = 1; m_addr = ld_addr; m_data = 64'd0;
      end
    end
  end

  task automatic drive(input bit ret, input bit ack, input bit lq, input logic [63:0] la);
    @(posedge clk);
    #1;
    rob_st_retire = ret;
    mem_ack       = ack;
    ld_req        = lq;
    ld_addr       = la;
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rob_st_retire = 1'b0; mem_ack = 1'b0; ld_req = 1'b0;
    ld_addr = 64'd0; sq_head_addr = 64'h100; sq_head_data = 64'hAB;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // One retire, ack two cycles into the store.
    drive(1, 0, 0, 64'd0); at_neg;
    check("one_ret_not_full", {63'd0, pend_full}, 64'd0);
    drive(0, 0, 0, 64'd0); at_neg;
    check("idle_before_store", {62'd0, mem_cmd}, 64'd0);
    drive(0, 0, 0, 64'd0); at_neg;
    check("st_cmd",  {62'd0, mem_cmd}, 64'd2);
    check("st_addr", mem_addr, 64'h100);
    check("st_data", mem_data, 64'hAB);
    check("st_no_pop_yet", {63'd0, sq_rt_en}, 64'd0);
    drive(0, 1, 0, 64'd0); at_neg;
    check("st_held", {62'd0, mem_cmd}, 64'd2);
    check("st_pop",  {63'd0, sq_rt_en}, 64'd1);
    drive(0, 0, 0, 64'd0); at_neg;
    check("st_done_idle", {62'd0, mem_cmd}, 64'd0);
    check("st_single_pulse", {63'd0, sq_rt_en}, 64'd0);

    // Fill to seven with the store un-acked, then overflow.
    sq_head_addr = 64'h300; sq_head_data = 64'hCD;
    repeat (7) drive(1, 0, 0, 64'd0);
    drive(1, 0, 0, 64'd0); at_neg;
    check("full_after_7", {63'd0, pend_full}, 64'd1);
    check("no_ovf_yet", {63'd0, ovf_err}, 64'd0);
    check("fill_store_addr", mem_addr, 64'h300);
    // Retire coincident with ack: counter stays at 7.
    drive(1, 1, 1, 64'h200); at_neg;
    check("ovf_set", {63'd0, ovf_err}, 64'd1);
    check("ack_pop", {63'd0, sq_rt_en}, 64'd1);
    check("model_cnt_hold", 64'(m_cnt), 64'd7);
    sq_head_addr = 64'h400; sq_head_data = 64'hEE;
    drive(0, 0, 1, 64'h200); at_neg;
    check("gap_idle", {62'd0, mem_cmd}, 64'd0);
    check("still_full", {63'd0, pend_full}, 64'd1);
    // Full forces store even though a store was granted last.
    drive(0, 0, 1, 64'h200); at_neg;
    check("full_store_first", {62'd0, mem_cmd}, 64'd2);
    check("full_store_addr", mem_addr, 64'h400);
    drive(0, 1, 1, 64'h200); at_neg;
    check("full_store_pop", {63'd0, sq_rt_en}, 64'd1);
    drive(0, 0, 1, 64'h200); at_neg;
    check("gap_idle2", {62'd0, mem_cmd}, 64'd0);
    check("not_full_6", {63'd0, pend_full}, 64'd0);
    drive(0, 0, 1, 64'h200); at_neg;
    check("ld_cmd",  {62'd0, mem_cmd}, 64'd1);
    check("ld_addr", mem_addr, 64'h200);
    check("ld_data", mem_data, 64'd0);
    drive(0, 1, 1, 64'h200); at_neg;
    check("ld_grant", {63'd0, ld_grant}, 64'd1);
    check("ld_no_pop", {63'd0, sq_rt_en}, 64'd0);
    drive(0, 0, 0, 64'd0); at_neg;
    check("ld_done_idle", {62'd0, mem_cmd}, 64'd0);

    // Reset while a store is outstanding and being acked.
    drive(0, 1, 0, 64'd0);
    #1;
    check("pre_rst_store", {62'd0, mem_cmd}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drops_cmd", {62'd0, mem_cmd}, 64'd0);
    check("rst_no_pop", {63'd0, sq_rt_en}, 64'd0);
    check("rst_clr_ovf", {63'd0, ovf_err}, 64'd0);
    drive(0, 0, 0, 64'd0);
    rst_n = 1'b1;
    at_neg;
    check("post_rst_idle", {62'd0, mem_cmd}, 64'd0);
    check("model_cnt_rst", 64'(m_cnt), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      sq_head_addr  = {$urandom, $urandom};
      sq_head_data  = {$urandom, $urandom};
      rob_st_retire = ($urandom_range(0, 3) == 0) && (m_cnt != 7 || $urandom_range(0, 31) == 0);
      mem_ack       = ($urandom_range(0, 2) == 0);
      if (ld_req) begin
        if (exp_ld_grant) begin
          ld_req = ($urandom_range(0, 1) == 1);
          if (ld_req) ld_addr = {$urandom, $urandom};
        end else if ($urandom_range(0, 99) == 0) begin
          ld_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        ld_req  = 1'b1;
        ld_addr = {$urandom, $urandom};
      end
      if (i % 700 == 350) begin
        #2 rst_n = 1'b0;
      end
    end

    drive(0, 0, 0, 64'd0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sq_commit_arb.md
SQ_COMMIT_ARB -- requirements
Module: sq_commit_arb

Interface
REQ-001 Parameter CNT_W, default 3; width of pending-commit counter, max pending = 2^CNT_W - 1 (7).
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 rob_st_retire  in  1  pulse: ROB retired one store this cycle.
REQ-005 sq_head_addr  in  64  address of store at SQ head.
REQ-006 sq_head_data  in  64  data of store at SQ head.
REQ-007 ld_req  in  1  load unit requests memory; held until ld_grant.
REQ-008 ld_addr  in  64  load address, stable while ld_req=1.
REQ-009 mem_ack  in  1  memory accepted the command driven this cycle.
REQ-010 mem_cmd  out  2  0=NONE, 1=LOAD, 2=STORE.
REQ-011 mem_addr  out  64  command address.
REQ-012 mem_data  out  64  store data; 0 unless mem_cmd=STORE.
REQ-013 sq_rt_en  out  1  pulse: pop SQ head (drives SQ retire input).
REQ-014 ld_grant  out  1  pulse: load command accepted by memory.
REQ-015 pend_full  out  1  pending counter at max; ROB shall not retire a store.
REQ-016 ovf_err  out  1  sticky: rob_st_retire seen while pend_full.

Function
REQ-017 States IDLE, ST_REQ, LD_REQ; mem_cmd, mem_addr, mem_data registered.
REQ-018 pend_cnt: +1 on rob_st_retire (unless pend_full), -1 on sq_rt_en; both same cycle -> unchanged.
REQ-019 rob_st_retire while pend_full: counter unchanged, ovf_err set until reset.
REQ-020 IDLE: store pending = pend_cnt!=0; load pending = ld_req.
REQ-021 IDLE, store only -> ST_REQ next cycle with mem_cmd=2, mem_addr=sq_head_addr, mem_data=sq_head_data latched at transition.
REQ-022 IDLE, load only -> LD_REQ next cycle with mem_cmd=1, mem_addr=ld_addr latched, mem_data=0.
REQ-023 IDLE, both pending: pend_full -> store; else round-robin, grant opposite of last granted type (last_st flag, reset 0 -> store first).
REQ-024 ST_REQ/LD_REQ: command held unchanged every cycle until mem_ack.
REQ-025 ST_REQ and mem_ack: sq_rt_en=1 same cycle (combinational), last_st<=1, next state IDLE, mem_cmd=0.
REQ-026 LD_REQ and mem_ack: ld_grant=1 same cycle, last_st<=0, next state IDLE, mem_cmd=0.
REQ-027 Every command followed by >=1 IDLE cycle so SQ head advances before next store latch.
REQ-028 mem_ack in IDLE ignored; sq_rt_en, ld_grant never both 1.
REQ-029 ld_req dropping while LD_REQ: command still held to mem_ack (requester protocol violation, no recovery).
REQ-030 rob_st_retire counted in any state, including the cycle of mem_ack.

Reset
REQ-031 reset=0: state IDLE, pend_cnt=0, last_st=0, ovf_err=0, mem_cmd=0, mem_addr=0, mem_data=0, sq_rt_en=0, ld_grant=0, pend_full=0.
REQ-032 reset mid-command: command dropped immediately, no sq_rt_en/ld_grant issued.
REQ-033 First IDLE evaluation on first rising edge after reset release.

Verification
REQ-034 One retire, head addr 0x100 data 0xAB, mem_ack 2 cycles after STORE -> mem_cmd=2 held 2 cycles, sq_rt_en one pulse, pend_cnt 1->0.
REQ-035 pend_cnt=2 and ld_req held (ld_addr 0x200), mem_ack immediate -> order STORE, LOAD, STORE with IDLE gap between each.
REQ-036 Seven retires, no ack -> pend_full=1; eighth retire -> ovf_err=1, pend_cnt=7.
REQ-037 rob_st_retire coincident with mem_ack in ST_REQ, pend_cnt=3 -> pend_cnt stays 3, sq_rt_en=1.
REQ-038 pend_full=1, last_st=1, ld_req=1 -> store granted before load.
REQ-039 reset asserted while ST_REQ -> mem_cmd=0 without clock edge, no sq_rt_en, pend_cnt=0.
